rng_share_ctrl: RTL and testbench

- Arbitrates one 8-bit Galois LFSR (taps 8,6,5,4) between two requesters in the VGA random-pattern path, e.g. a pixel-colour consumer and a sprite/position consumer.
- Per granted request, steps the LFSR STEPS times to decorrelate successive bytes, then returns the byte with a one-cycle ack.
- Handles seed loading and guards against LFSR lock-up.

---
 rtl/rng_share_ctrl_pkg.sv | 17 +
 rtl/rng_share_ctrl_lfsr8_step.sv | 12 +
 rtl/rng_share_ctrl.sv | 105 ++++++++++
 tb/tb_rng_share_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/rng_share_ctrl_pkg.sv
// rtl/rng_share_ctrl_pkg.sv - shared types and constants for the shared RNG controller
package rng_share_ctrl_pkg;

    localparam int LFSR_W = 8;
    localparam logic [LFSR_W-1:0] LOCKUP_SEED = 8'h01;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        ACK  = 2'd2
    } state_t;

    function automatic logic [1:0] owner_onehot(input logic owner);
        return owner ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rng_share_ctrl_lfsr8_step.sv
// rtl/rng_share_ctrl_lfsr8_step.sv - combinational next state of the 8-bit Galois LFSR (taps 8,6,5,4)
module lfsr8_step
    import rng_share_ctrl_pkg::*;
(
    input  logic [LFSR_W-1:0] i_state,
    output logic [LFSR_W-1:0] o_state
);

    assign o_state = {i_state[0], i_state[7], i_state[0] ^ i_state[6], i_state[0] ^ i_state[5],
                      i_state[0] ^ i_state[4], i_state[3], i_state[2], i_state[1]};

endmodule

// File: rtl/rng_share_ctrl.sv
// rtl/rng_share_ctrl.sv - two-requester round-robin share of one LFSR; RNG_SHARE_FREERUN_EN steps it in IDLE
module rng_share_ctrl
    import rng_share_ctrl_pkg::*;
#(
    parameter int unsigned STEPS = 8,
    parameter logic [7:0]  SEED  = 8'd100
) (
    input  logic       i_clk,
    input  logic       i_nreset,
    input  logic       i_seed_load,
    input  logic [7:0] i_seed,
    input  logic [1:0] i_req,
    output logic [1:0] o_ack,
    output logic [7:0] o_data,
    output logic       o_busy
);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] lfsr;
    logic [7:0] lfsr_nxt;
    logic [7:0] step_cnt;
    logic [7:0] seed_hold;
    logic       seed_pend;
    logic       owner;
    logic       rr_ptr;

    // A fresh pulse in IDLE wins over an older held seed.
    logic       seed_now;
    logic [7:0] seed_sel;
    logic       grant;
    logic       last_step;
    logic       owner_req;

    assign seed_now  = seed_pend | i_seed_load;
    assign seed_sel  = i_seed_load ? i_seed : seed_hold;
    assign grant     = (i_req == 2'b11) ? ~rr_ptr : i_req[1];
    assign last_step = (step_cnt == 8'(STEPS - 1));
    assign owner_req = i_req[owner];

    lfsr8_step u_step (
        .i_state(lfsr),
        .o_state(lfsr_nxt)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!seed_now && (i_req != 2'b00)) state_nxt = STEP;
            STEP: begin
                if (!owner_req)     state_nxt = IDLE;
                else if (last_step) state_nxt = ACK;
            end
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_nreset) begin
        if (!i_nreset) begin
            state     <= IDLE;
            lfsr      <= SEED;
            step_cnt  <= 8'd0;
            seed_hold <= 8'd0;
            seed_pend <= 1'b0;
            owner     <= 1'b0;
            rr_ptr    <= 1'b1;
            o_data    <= 8'd0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (seed_now) begin
                        lfsr      <= (seed_sel == 8'd0) ? LOCKUP_SEED : seed_sel;
                        seed_pend <= 1'b0;
                    end else begin
`ifdef RNG_SHARE_FREERUN_EN
                        lfsr <= lfsr_nxt;
`endif
                        if (i_req != 2'b00) begin
                            owner    <= grant;
                            step_cnt <= 8'd0;
                        end
                    end
                end
                STEP: begin
                    lfsr     <= lfsr_nxt;
                    step_cnt <= step_cnt + 8'd1;
                    if (owner_req && last_step) o_data <= lfsr_nxt;
                end
                ACK:     rr_ptr <= owner;
                default: ;
            endcase
            // Seeds arriving mid-transaction wait for the next IDLE cycle.
            if (state != IDLE && i_seed_load) begin
                seed_pend <= 1'b1;
                seed_hold <= i_seed;
            end
        end
    end

    assign o_ack  = (state == ACK) ? owner_onehot(owner) : 2'b00;
    assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_rng_share_ctrl.sv
// tb/tb_rng_share_ctrl.sv - randomized self-checking bench for rng_share_ctrl against a transaction model
module tb_rng_share_ctrl;

    localparam int         STEPS = 8;
    localparam logic [7:0] SEED  = 8'd100;

    logic       i_clk = 1'b0;
    logic       i_nreset;
    logic       i_seed_load;
    logic [7:0] i_seed;
    logic [1:0] i_req;
    logic [1:0] o_ack;
    logic [7:0] o_data;
    logic       o_busy;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] m_lfsr;
    logic [7:0] m_seed;
    logic       m_pend;
    int         m_rr;

    always #5 i_clk = ~i_clk;

    rng_share_ctrl #(.STEPS(STEPS), .SEED(SEED)) dut (
        .i_clk(i_clk),
        .i_nreset(i_nreset),
        .i_seed_load(i_seed_load),
        .i_seed(i_seed),
        .i_req(i_req),
        .o_ack(o_ack),
        .o_data(o_data),
        .o_busy(o_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [7:0] m_adv(input logic [7:0] r, input int n);
        logic [7:0] v;
        v = r;
        for (int i = 0; i < n; i++) v = (v >> 1) ^ (v[0] ? 8'hB8 : 8'h00);
        return v;
    endfunction

    function automatic logic [7:0] nz(input logic [7:0] s);
        return (s == 8'd0) ? 8'h01 : s;
    endfunction

    task automatic model_reset();
        m_lfsr = SEED;
        m_seed = 8'd0;
        m_pend = 1'b0;
        m_rr   = 1;
    endtask

    task automatic serve(input int r, input int seed_at, input logic [7:0] sv);
        int n;
        int off;
        logic [7:0] exp_d;
        off = m_pend ? 1 : 0;
        if (m_pend) begin
            m_lfsr = nz(m_seed);
            m_pend = 1'b0;
        end
        exp_d = m_adv(m_lfsr, STEPS);
        i_req[r] = 1'b1;
        n = 0;
        while (n < 40) begin
            @(negedge i_clk);
            n++;
            if (o_ack != 2'b00) break;
            i_seed_load = (seed_at != 0) && (n == seed_at + off);
            i_seed = sv;
        end
        i_seed_load = 1'b0;
        i_req[r] = 1'b0;
        check("latency", n, STEPS + 1 + off);
        check("ack_owner", o_ack, 1 << r);
        check("ack_data", o_data, exp_d);
        m_lfsr = exp_d;
        m_rr = r;
        if (seed_at != 0) begin
            m_pend = 1'b1;
            m_seed = sv;
        end
        @(negedge i_clk);
        check("ack_one_cycle", o_ack, 0);
        check("busy_after_ack", o_busy, 0);
        check("data_hold", o_data, exp_d);
    endtask

    task automatic seed_idle(input logic [7:0] s);
        i_seed_load = 1'b1;
        i_seed = s;
        @(negedge i_clk);
        i_seed_load = 1'b0;
        m_lfsr = nz(s);
        m_pend = 1'b0;
        check("seed_busy", o_busy, 0);
    endtask

    task automatic drop(input int r, input int d);
        int off;
        logic seen;
        off = m_pend ? 1 : 0;
        if (m_pend) begin
            m_lfsr = nz(m_seed);
            m_pend = 1'b0;
        end
        seen = 1'b0;
        i_req[r] = 1'b1;
        for (int k = 1; k <= d + off; k++) begin
            @(negedge i_clk);
            if (o_ack != 2'b00) seen = 1'b1;
        end
        i_req[r] = 1'b0;
        @(negedge i_clk);
        if (o_ack != 2'b00) seen = 1'b1;
        check("drop_no_ack", seen, 0);
        check("drop_idle", o_busy, 0);
        m_lfsr = m_adv(m_lfsr, d);
    endtask

    task automatic back_to_back();
        int n;
        int lowc;
        int own;
        logic [7:0] exp_d;
        own = (m_rr == 1) ? 0 : 1;
        i_req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            lowc = 0;
            exp_d = m_adv(m_lfsr, STEPS);
            while (n < 40) begin
                @(negedge i_clk);
                n++;
                if (o_ack != 2'b00) break;
                if (!o_busy) lowc++;
            end
            check("b2b_spacing", n, (k == 0) ? STEPS + 1 : STEPS + 2);
            if (k > 0) check("b2b_idle_gap", lowc, 1);
            check("b2b_owner", o_ack, 1 << own);
            check("b2b_data", o_data, exp_d);
            m_lfsr = exp_d;
            m_rr = own;
            own = 1 - own;
        end
        i_req = 2'b00;
        @(negedge i_clk);
        check("b2b_busy_end", o_busy, 0);
    endtask

    task automatic reset_mid_step();
        i_req[0] = 1'b1;
        repeat (3) @(negedge i_clk);
        #2 i_nreset = 1'b0;
        #1;
        check("rst_busy", o_busy, 0);
        check("rst_ack", o_ack, 0);
        check("rst_data", o_data, 0);
        i_req = 2'b00;
        model_reset();
        @(negedge i_clk);
        i_nreset = 1'b1;
    endtask

    initial begin
        i_nreset = 1'b0;
        i_seed_load = 1'b0;
        i_seed = 8'd0;
        i_req = 2'b00;
        model_reset();
        repeat (2) @(negedge i_clk);
        check("reset_busy", o_busy, 0);
        check("reset_ack", o_ack, 0);
        check("reset_data", o_data, 0);
        i_nreset = 1'b1;

        serve(0, 0, 8'd0);
        check("first_byte", o_data, 8'h93);

        reset_mid_step();
        serve(0, 0, 8'd0);
        check("byte_after_reset", o_data, 8'h93);

        seed_idle(8'h00);
        serve($urandom_range(0, 1), 0, 8'd0);

        serve(0, 3, 8'hA5);
        serve(1, 0, 8'd0);

        drop(1, 4);
        serve(0, 0, 8'd0);

        back_to_back();

        for (int it = 0; it < 30; it++) begin
            case ($urandom_range(0, 3))
                0: serve($urandom_range(0, 1), 0, 8'd0);
                1: serve($urandom_range(0, 1), $urandom_range(1, STEPS), 8'($urandom_range(0, 255)));
                2: seed_idle(($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255)));
                default: drop($urandom_range(0, 1), $urandom_range(1, STEPS));
            endcase
        end
        serve($urandom_range(0, 1), 0, 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
